// File: rtl/ev22_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ev22_pkg
// Description : Shared constants, types and address helpers for the EV22
//               register-file write side.
// Revision    : 1.0 - initial release
// ============================================================================
package ev22_pkg;

    localparam int DATA_W = 16;
    localparam int N_GPR  = 28;
    localparam int SEL_W  = 6;

    // Register-file write address map
    localparam logic [SEL_W-1:0] ADDR_PI0  = 6'd28;
    localparam logic [SEL_W-1:0] ADDR_PI1  = 6'd29;
    localparam logic [SEL_W-1:0] ADDR_OP0  = 6'd30;
    localparam logic [SEL_W-1:0] ADDR_OP1  = 6'd31;
    localparam logic [SEL_W-1:0] ADDR_WREG = 6'd34;

    // Which write source wins the single write slot this cycle
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ALU  = 2'd1,
        SRC_PEND = 2'd2,
        SRC_LOAD = 2'd3
    } commit_src_e;

    // True when a write to this address lands in real storage.
    // The input-port registers (28, 29) are read-only and everything
    // outside the map is unmapped.
    function automatic logic addr_is_writable(input logic [SEL_W-1:0] sel);
        return (sel < SEL_W'(N_GPR)) || (sel == ADDR_OP0) ||
               (sel == ADDR_OP1) || (sel == ADDR_WREG);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync2.sv
`default_nettype none
// ============================================================================
// Module      : sync2
// Description : Two-flop synchronizer for an asynchronous input bus.
// Revision    : 1.0 - initial release
// ============================================================================
module sync2 #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] meta_q, meta_d;
    logic [DATA_W-1:0] sync_q, sync_d;

    // Next-state: shift the async sample one stage per clock
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer stages, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/regfile_write_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_port
// Description : EV22 register-file write side. Holds r0..r27, the output-port
//               registers, the working register and synchronized input
//               ports; arbitrates ALU and load write-back through a
//               one-entry pending buffer (priority ALU > pending > new load).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_port
    import ev22_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int N_GPR  = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Alu_Valid,
    input  logic [5:0]        Alu_Sel,
    input  logic [DATA_W-1:0] Alu_Data,
    input  logic              Ld_Valid,
    output logic              Ld_Ready,
    input  logic [5:0]        Ld_Sel,
    input  logic [DATA_W-1:0] Ld_Data,
    input  logic [DATA_W-1:0] Port_In_0,
    input  logic [DATA_W-1:0] Port_In_1,
    output logic [DATA_W-1:0] r0,  r1,  r2,  r3,  r4,  r5,  r6,  r7,
    output logic [DATA_W-1:0] r8,  r9,  r10, r11, r12, r13, r14, r15,
    output logic [DATA_W-1:0] r16, r17, r18, r19, r20, r21, r22, r23,
    output logic [DATA_W-1:0] r24, r25, r26, r27,
    output logic [DATA_W-1:0] r28, r29,
    output logic [DATA_W-1:0] r32, r33,
    output logic [DATA_W-1:0] Working_Register,
    output logic              Wr_Err
);

    logic [DATA_W-1:0] gpr_q [N_GPR];
    logic [DATA_W-1:0] gpr_d [N_GPR];
    logic [DATA_W-1:0] op0_q, op0_d, op1_q, op1_d, wreg_q, wreg_d;

    logic              pend_full_q, pend_full_d;
    logic [5:0]        pend_sel_q,  pend_sel_d;
    logic [DATA_W-1:0] pend_data_q, pend_data_d;
    logic              wr_err_q,    wr_err_d;

    commit_src_e       commit_src;
    logic              commit_valid;
    logic [5:0]        commit_sel;
    logic [DATA_W-1:0] commit_data;
    logic              ld_accept;

    // Arbitration: pick the one write that commits this edge and decide
    // whether the pending buffer captures, drains or holds.
    always_comb begin
        ld_accept   = Ld_Valid & ~pend_full_q;
        commit_src  = SRC_NONE;
        commit_sel  = '0;
        commit_data = '0;
        pend_full_d = pend_full_q;
        pend_sel_d  = pend_sel_q;
        pend_data_d = pend_data_q;
        if (Alu_Valid) begin
            commit_src  = SRC_ALU;
            commit_sel  = Alu_Sel;
            commit_data = Alu_Data;
            // ALU owns the slot; park an accepted load until a free cycle
            if (ld_accept) begin
                pend_full_d = 1'b1;
                pend_sel_d  = Ld_Sel;
                pend_data_d = Ld_Data;
            end
        end else if (pend_full_q) begin
            commit_src  = SRC_PEND;
            commit_sel  = pend_sel_q;
            commit_data = pend_data_q;
            pend_full_d = 1'b0;
        end else if (Ld_Valid) begin
            commit_src  = SRC_LOAD;
            commit_sel  = Ld_Sel;
            commit_data = Ld_Data;
        end
        commit_valid = (commit_src != SRC_NONE);
    end

    // Address decode of the committed write into next register state
    always_comb begin
        for (int i = 0; i < N_GPR; i++) begin
            gpr_d[i] = gpr_q[i];
        end
        op0_d  = op0_q;
        op1_d  = op1_q;
        wreg_d = wreg_q;
        if (commit_valid) begin
            for (int i = 0; i < N_GPR; i++) begin
                if (commit_sel == SEL_W'(i)) begin
                    gpr_d[i] = commit_data;
                end
            end
            if (commit_sel == ADDR_OP0)  op0_d  = commit_data;
            if (commit_sel == ADDR_OP1)  op1_d  = commit_data;
            if (commit_sel == ADDR_WREG) wreg_d = commit_data;
        end
        wr_err_d = commit_valid & ~addr_is_writable(commit_sel);
    end

    // Register storage, pending buffer and error pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            op0_q       <= '0;
            op1_q       <= '0;
            wreg_q      <= '0;
            pend_full_q <= 1'b0;
            pend_sel_q  <= '0;
            pend_data_q <= '0;
            wr_err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < N_GPR; i++) begin
                gpr_q[i] <= gpr_d[i];
            end
            op0_q       <= op0_d;
            op1_q       <= op1_d;
            wreg_q      <= wreg_d;
            pend_full_q <= pend_full_d;
            pend_sel_q  <= pend_sel_d;
            pend_data_q <= pend_data_d;
            wr_err_q    <= wr_err_d;
        end
    end

    sync2 #(.DATA_W(DATA_W)) u_sync_pi0 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (Port_In_0),
        .q     (r28)
    );

    sync2 #(.DATA_W(DATA_W)) u_sync_pi1 (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (Port_In_1),
        .q     (r29)
    );

    assign Ld_Ready         = ~pend_full_q;
    assign Wr_Err           = wr_err_q;
    assign r32              = op0_q;
    assign r33              = op1_q;
    assign Working_Register = wreg_q;

    assign r0  = gpr_q[0];   assign r1  = gpr_q[1];   assign r2  = gpr_q[2];
    assign r3  = gpr_q[3];   assign r4  = gpr_q[4];   assign r5  = gpr_q[5];
    assign r6  = gpr_q[6];   assign r7  = gpr_q[7];   assign r8  = gpr_q[8];
    assign r9  = gpr_q[9];   assign r10 = gpr_q[10];  assign r11 = gpr_q[11];
    assign r12 = gpr_q[12];  assign r13 = gpr_q[13];  assign r14 = gpr_q[14];
    assign r15 = gpr_q[15];  assign r16 = gpr_q[16];  assign r17 = gpr_q[17];
    assign r18 = gpr_q[18];  assign r19 = gpr_q[19];  assign r20 = gpr_q[20];
    assign r21 = gpr_q[21];  assign r22 = gpr_q[22];  assign r23 = gpr_q[23];
    assign r24 = gpr_q[24];  assign r25 = gpr_q[25];  assign r26 = gpr_q[26];
    assign r27 = gpr_q[27];

endmodule
`default_nettype wire

// File: doc/regfile_write_port.md
# regfile_write_port

Write side of the EV22 register file: owns storage for general registers r0..r27, the two output-port registers and the working register (r34), plus synchronized input-port registers r28/r29. Accepts write-back from the ALU and from the load path, arbitrates between them with a one-entry pending buffer, and drives every register value to the combinational read mux (Data_A/Data_B selection) that feeds the datapath.

## Interface
- DATA_W, 16, register width
- N_GPR, 28, number of general-purpose registers (addresses 0..27)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- Alu_Valid  input  1  ALU write-back request this cycle (always accepted)
- Alu_Sel  input  6  ALU destination address
- Alu_Data  input  DATA_W  ALU write data
- Ld_Valid  input  1  load write-back request
- Ld_Ready  output  1  load request accepted when Ld_Valid & Ld_Ready
- Ld_Sel  input  6  load destination address
- Ld_Data  input  DATA_W  load write data
- Port_In_0, Port_In_1  input  DATA_W each  asynchronous external input ports
- r0..r27  output  DATA_W each  general registers
- r28, r29  output  DATA_W each  synchronized PI0/PI1
- r32, r33  output  DATA_W each  output-port registers (Output_Port_0/1)
- Working_Register  output  DATA_W  r34
- Wr_Err  output  1  one-cycle pulse: a committed write targeted an illegal address

## Operation
- Address map for writes: 0..27 → r0..r27; 30 → r32 (Output_Port_0); 31 → r33 (Output_Port_1); 34 → Working_Register. 28, 29 read-only; 32, 33, 35..63 unmapped.
- Write to read-only or unmapped address: no register changes, Wr_Err pulses.
- Pending buffer: one entry {sel, data}, flag Pend_Full. Ld_Ready = ~Pend_Full.
- Per cycle, commit source priority: ALU > pending > new load.
  - Alu_Valid: commit ALU. If Ld_Valid & Ld_Ready, capture load into pending.
  - else Pend_Full: commit pending, clear Pend_Full. Ld_Ready is 0 this cycle, no new load accepted.
  - else Ld_Valid (Ld_Ready=1): commit load directly, pending untouched.
- At most one register write per edge. Same-address ALU+load in one cycle: ALU value written first, load value overwrites on a later drain cycle (load is final).
- Pending holds indefinitely under continuous Alu_Valid; Ld_Ready stays 0 until drain.
- r28/r29: Port_In_x passed through a two-flop synchronizer each cycle, regardless of writes.

## Timing
- Reset (async assert, sync-to-clk deassert handled upstream): all register outputs 0, synchronizer flops 0, Pend_Full 0, Ld_Ready 1, Wr_Err 0.
- Write latency: request at edge N → register output updated after edge N (visible cycle N+1).
- Buffered load: accepted edge N, committed at first edge with no Alu_Valid and Pend_Full=1.
- Ld_Ready low from the cycle after capture through the drain cycle; high the cycle after drain.
- Wr_Err registered: high for exactly the cycle after the offending commit.
- Port_In_x change → r28/r29 reflect it after 2 edges.
- Reset mid-operation: pending entry discarded, no partial write.

## Structure
- Shared package ev22_pkg: DATA_W, address constants ADDR_PI0=28, ADDR_PI1=29, ADDR_OP0=30, ADDR_OP1=31, ADDR_WREG=34, and an addr_is_writable function.
- Sub-module sync2 (two-flop synchronizer, DATA_W wide, async active-low reset), instantiated twice.
- Pending buffer and commit mux in the top module.

## Test plan
- Reset then Alu_Valid, Alu_Sel=5, Alu_Data=0x1234 → r5=0x1234 next cycle, all others 0, Ld_Ready=1.
- Same cycle Alu_Sel=3/0xAAAA and Ld_Sel=3/0x5555 → r3=0xAAAA, Ld_Ready=0; idle cycle → r3=0x5555, Ld_Ready=1 after.
- Alu_Valid held 4 cycles while load pending (Ld_Sel=7, 0xBEEF) → r7 unchanged, Ld_Ready=0 all 4; first idle cycle r7=0xBEEF.
- Writes to 28, 33, 40 → no register change, Wr_Err pulses one cycle each; write 30/0x00FF → r32=0x00FF; write 34/0xC0DE → Working_Register=0xC0DE.
- Port_In_0=0x0F0F → r28=0x0F0F exactly 2 edges later.
- rst_n asserted while Pend_Full=1 → all outputs 0 immediately, Ld_Ready=1, buffered data never written after release.
